divider_toplevel: RTL and testbench
===================================

Name: divider_toplevel

Overview:
- Sequential unsigned restoring divider. It is the inverse-operation companion to the lab-4 shift-add multiplier.
- It uses the same switch-driven operator interface: Reset_Load_Clear captures the operand on SW, and Run starts the operation.
- It produces quotient and remainder over WIDTH iterations, one bit per clock.
- It sits at the lab top level alongside the multiplier and drives result registers for display and testbench checking.

Parameters:
WIDTH, 8, operand width in bits (dividend, divisor, quotient and remainder).

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Reset_Load_Clear  input  1  asynchronous active-high reset; clears state; also synchronously loads the divisor from SW while high
Run  input  1  start request; level input, rising-edge qualified by the FSM
SW  input  WIDTH  operand switches: divisor while Reset_Load_Clear is high, dividend when Run is first accepted
Qval  output  WIDTH  quotient register
Rval  output  WIDTH  remainder register
Dval  output  WIDTH  divisor register
Done  output  1  high while results are valid and Run is still held
DivZero  output  1  last operation had a divisor of zero

Behaviour:
- Reset (Reset_Load_Clear=1, asynchronous):
  - State goes to IDLE.
  - Qval=0, Rval=0, DivZero=0, Done=0, iteration counter=0.
  - The Dval register has no async reset. On every Clk edge with Reset_Load_Clear=1 it loads SW, so Dval=SW one edge after assertion.
- States: IDLE, CALC, HOLD. Encoded as an enum from the package.
- IDLE, on an edge with Run=1:
  - If Dval!=0: load Q=SW, internal R (WIDTH+1 bits)=0, counter=0, go to CALC.
  - If Dval==0: Qval=all ones, Rval=SW, DivZero=1, go directly to HOLD.
  - In both cases DivZero is rewritten at start; it is cleared when Dval!=0.
- CALC, one restoring step per edge:
  - Form {R,Q} shifted left by 1.
  - trial = R_shifted - {1'b0,Dval}, computed at WIDTH+1 bits.
  - If trial is non-negative (MSB=0): R=trial and Q[0]=1. Otherwise R is unchanged (already shifted) and Q[0]=0.
  - Counter increments each step. After the WIDTH-th step, go to HOLD.
- Rval is R[WIDTH-1:0]. Invariant: R < Dval at every step.
- Latency:
  - The start edge is edge 0. Steps occur on edges 1..WIDTH.
  - Done=1 and final results are visible after edge WIDTH: 9 edges for WIDTH=8.
  - For the divide-by-zero case, Done=1 after edge 0.
- HOLD:
  - Done=1.
  - Run is ignored while high; no retrigger even if it is held indefinitely.
  - Run=0 moves to IDLE and Done goes to 0. Qval, Rval and DivZero hold until the next start or reset.
- Back-to-back operations: a new start needs Run to drop in HOLD, then rise again. The divisor is retained, so no reload is needed.
- SW changes during CALC have no effect. Run toggling during CALC is ignored.
- Reset_Load_Clear asserted mid-CALC: asynchronous abort to IDLE, outputs cleared, divisor reloaded on the next edge.
- Run and Reset_Load_Clear high together: reset wins and the FSM stays in IDLE. Run is accepted on the first edge after release if Run is still high.
- Full-range operands are legal, e.g. 255/255 gives Q=1, R=0.

Decomposition:
- Package div_pkg: WIDTH default constant; state enum typedef {IDLE, CALC, HOLD}; counter width constant $clog2(WIDTH+1).
- Sub-module div_step: a combinational restoring cell.
  - Inputs: R, Q, D. Outputs: R_next, Q_next.
  - Instantiated once and used by the datapath each CALC cycle.
- FSM and registers live in divider_toplevel.

Test Plan:
- Reset_Load_Clear=1 with SW=7 for 3 cycles, release, SW=200, Run=1 for 20 cycles -> Done after 9 edges, Qval=28, Rval=4, DivZero=0.
- Divisor 1, dividend 255 -> Qval=255, Rval=0. Divisor 9, dividend 5 -> Qval=0, Rval=5. Divisor 255, dividend 255 -> Qval=1, Rval=0.
- Divisor 0, dividend 100, Run=1 -> Done after 1 edge, Qval=255, Rval=100, DivZero=1. Then divisor 3, dividend 10 -> DivZero=0, Qval=3, Rval=1.
- Divisor 7; run dividend 49; drop Run; run dividend 50 with no reload -> Qval=7, Rval=0, then Qval=7, Rval=1. Run held 40 cycles -> exactly one operation, and Done stays high.
- Reset_Load_Clear pulsed at step 4 of 200/7 -> Qval=0, Rval=0, Done=0 immediately (async), Dval=SW after the next edge. A subsequent run completes correctly.
- Random: 100 pairs from $random, skipping divisor 0 -> for each, Qval*Dval+Rval == dividend and Rval < Dval. Error count 0.

Source files
------------

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the sequential restoring divider.
//   WIDTH   : default operand width (dividend, divisor, quotient, remainder)
//   CNT_W   : width of the iteration counter, large enough to hold WIDTH
//   state_t : controller states
//             IDLE - waiting for Run
//             CALC - one restoring step per clock
//             HOLD - results valid, waiting for Run to drop
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if
// Operator-side bundle of the divider: switch and run inputs plus the
// result registers shown on the display.
//   Run     : start request (level)
//   SW      : operand switches (divisor during load, dividend at start)
//   Qval    : quotient register
//   Rval    : remainder register
//   Dval    : divisor register
//   Done    : results valid while Run is still held
//   DivZero : last operation had a zero divisor
// The master modport is the operator/bench side; the slave modport is the
// divider itself.
// ---------------------------------------------------------------------------
interface div_if #(
    parameter int WIDTH = div_pkg::WIDTH
);

    logic             Run;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Qval;
    logic [WIDTH-1:0] Rval;
    logic [WIDTH-1:0] Dval;
    logic             Done;
    logic             DivZero;

    modport master (
        output Run,
        output SW,
        input  Qval,
        input  Rval,
        input  Dval,
        input  Done,
        input  DivZero
    );

    modport slave (
        input  Run,
        input  SW,
        output Qval,
        output Rval,
        output Dval,
        output Done,
        output DivZero
    );

endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// Combinational restoring-division cell: performs one shift/trial-subtract
// step on the partial remainder and quotient/dividend shift register.
//   r_in   [WIDTH:0]   : partial remainder before the step
//   q_in   [WIDTH-1:0] : quotient/dividend shift register before the step
//   d_in   [WIDTH-1:0] : divisor
//   r_next [WIDTH:0]   : partial remainder after the step
//   q_next [WIDTH-1:0] : shift register after the step, new quotient bit in
//                        bit 0
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // The remainder always stays below the divisor, so its top bit is zero
    // and the shifted value fits in WIDTH+1 bits. Keeping one extra guard bit
    // here lets the whole remainder feed the shift while the trial's sign is
    // still read from the top bit.
    always_comb begin
        shifted = {r_in, q_in[WIDTH-1]};
        trial   = shifted - {2'b00, d_in};
        if (!trial[WIDTH+1]) begin
            r_next = trial[WIDTH:0];
            q_next = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_next = shifted[WIDTH:0];
            q_next = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_toplevel.sv
// ---------------------------------------------------------------------------
// divider_toplevel
// Sequential unsigned restoring divider driven from the lab switch panel.
// Reset_Load_Clear clears the controller and loads the divisor from SW;
// Run starts a division of SW by the stored divisor. One quotient bit is
// produced per clock, so results appear WIDTH clocks after the start edge.
// A zero divisor skips the iterations and reports all-ones quotient,
// remainder equal to the dividend and DivZero set.
//   Clk              : system clock, rising edge
//   Reset_Load_Clear : async active-high clear, synchronous divisor load
//   bus (div_if.slave): Run, SW in; Qval, Rval, Dval, Done, DivZero out
// ---------------------------------------------------------------------------
module divider_toplevel
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic Clk,
    input  logic Reset_Load_Clear,
    div_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] d_q;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    // Single restoring cell shared by every iteration of the datapath.
    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in   (r_q),
        .q_in   (q_q),
        .d_in   (d_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    // Divisor register: deliberately without async clear so that holding
    // Reset_Load_Clear acts as the "load divisor" operation. It keeps its
    // value across operations, allowing back-to-back runs without reload.
    always_ff @(posedge Clk) begin
        if (Reset_Load_Clear) begin
            d_q <= bus.SW;
        end
    end

    // Controller and result registers, cleared asynchronously so an abort
    // mid-calculation takes effect without waiting for a clock.
    always_ff @(posedge Clk or posedge Reset_Load_Clear) begin
        if (Reset_Load_Clear) begin
            state_q    <= IDLE;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state logic. IDLE starts on Run (level), CALC runs WIDTH steps,
    // HOLD waits for Run to drop so a held Run never retriggers.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.Run) begin
                    if (d_q != '0) begin
                        q_d        = bus.SW;
                        r_d        = '0;
                        cnt_d      = '0;
                        div_zero_d = 1'b0;
                        state_d    = CALC;
                    end else begin
                        q_d        = '1;
                        r_d        = {1'b0, bus.SW};
                        div_zero_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end

            CALC: begin
                q_d   = step_q;
                r_d   = step_r;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (!bus.Run) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mapping straight from the registers.
    assign bus.Qval    = q_q;
    assign bus.Rval    = r_q[WIDTH-1:0];
    assign bus.Dval    = d_q;
    assign bus.Done    = (state_q == HOLD);
    assign bus.DivZero = div_zero_q;

endmodule

// File: tb/tb_divider_toplevel.sv
// ---------------------------------------------------------------------------
// tb_divider_toplevel
// Self-checking bench for divider_toplevel: directed cases followed by
// random operand pairs, all compared against plain-arithmetic results.
// ---------------------------------------------------------------------------
module tb_divider_toplevel;

    import div_pkg::*;

    localparam int W = WIDTH;

    logic Clk = 1'b0;
    logic Reset_Load_Clear;

    div_if #(.WIDTH(W)) bus ();

    divider_toplevel #(.WIDTH(W)) dut (
        .Clk              (Clk),
        .Reset_Load_Clear (Reset_Load_Clear),
        .bus              (bus)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] curDivisor;
    logic [W-1:0] lastQ;
    logic [W-1:0] lastR;
    logic         lastDz;

    // One comparison, counted and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hold Reset_Load_Clear with the divisor on SW for three edges.
    task automatic loadDivisor(input logic [W-1:0] d);
        @(negedge Clk);
        Reset_Load_Clear = 1'b1;
        bus.SW           = d;
        bus.Run          = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("dval_load", 32'(bus.Dval), 32'(d));
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
        curDivisor       = d;
    endtask

    // Start a division of a by the stored divisor, measure latency to Done,
    // then compare against ordinary integer division.
    task automatic applyStimulus(input string tag, input logic [W-1:0] a,
                                 input int expEdges);
        int edges;
        if (curDivisor == '0) begin
            lastQ  = '1;
            lastR  = a;
            lastDz = 1'b1;
        end else begin
            lastQ  = W'(int'(a) / int'(curDivisor));
            lastR  = W'(int'(a) % int'(curDivisor));
            lastDz = 1'b0;
        end
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
        bus.SW           = a;
        bus.Run          = 1'b1;
        edges            = 0;
        while (edges < 20) begin
            @(posedge Clk);
            #1;
            edges++;
            if (edges == 1) bus.SW = W'($urandom);
            if (bus.Done === 1'b1) break;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'(expEdges));
        checkOutput({tag, "_q"}, 32'(bus.Qval), 32'(lastQ));
        checkOutput({tag, "_r"}, 32'(bus.Rval), 32'(lastR));
        checkOutput({tag, "_dz"}, 32'(bus.DivZero), 32'(lastDz));
    endtask

    // Drop Run and confirm Done falls while results are held.
    task automatic releaseRun(input string tag);
        @(negedge Clk);
        bus.Run = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput({tag, "_done_low"}, 32'(bus.Done), 32'd0);
        checkOutput({tag, "_q_hold"}, 32'(bus.Qval), 32'(lastQ));
        checkOutput({tag, "_r_hold"}, 32'(bus.Rval), 32'(lastR));
    endtask

    initial begin
        int doneCount;
        logic [W-1:0] a;
        logic [W-1:0] d;

        // Reset state, divisor 7, then 200/7
        Reset_Load_Clear = 1'b1;
        bus.SW           = W'(7);
        bus.Run          = 1'b0;
        #1;
        checkOutput("rst_q", 32'(bus.Qval), 32'd0);
        checkOutput("rst_r", 32'(bus.Rval), 32'd0);
        checkOutput("rst_done", 32'(bus.Done), 32'd0);
        checkOutput("rst_dz", 32'(bus.DivZero), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_dval", 32'(bus.Dval), 32'd7);
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
        curDivisor       = W'(7);
        applyStimulus("200div7", W'(200), 9);
        releaseRun("200div7");

        // Boundary operands
        loadDivisor(W'(1));
        applyStimulus("255div1", W'(255), 9);
        releaseRun("255div1");
        loadDivisor(W'(9));
        applyStimulus("5div9", W'(5), 9);
        releaseRun("5div9");
        loadDivisor(W'(255));
        applyStimulus("255div255", W'(255), 9);
        releaseRun("255div255");

        // Divide by zero, then a normal run clears DivZero
        loadDivisor(W'(0));
        applyStimulus("100div0", W'(100), 1);
        releaseRun("100div0");
        loadDivisor(W'(3));
        applyStimulus("10div3", W'(10), 9);
        releaseRun("10div3");

        // Back-to-back without reload, then Run held for 40 cycles
        loadDivisor(W'(7));
        applyStimulus("49div7", W'(49), 9);
        releaseRun("49div7");
        applyStimulus("50div7", W'(50), 9);
        doneCount = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (bus.Done === 1'b1) doneCount++;
        end
        checkOutput("hold40_done", 32'(doneCount), 32'd40);
        checkOutput("hold40_q", 32'(bus.Qval), 32'd7);
        checkOutput("hold40_r", 32'(bus.Rval), 32'd1);
        releaseRun("50div7");

        // Asynchronous abort after step 4 of 200/7
        loadDivisor(W'(7));
        @(negedge Clk);
        bus.SW  = W'(200);
        bus.Run = 1'b1;
        repeat (5) @(posedge Clk);
        #2;
        Reset_Load_Clear = 1'b1;
        bus.SW           = W'(11);
        bus.Run          = 1'b0;
        #1;
        checkOutput("abort_q", 32'(bus.Qval), 32'd0);
        checkOutput("abort_r", 32'(bus.Rval), 32'd0);
        checkOutput("abort_done", 32'(bus.Done), 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("abort_dval", 32'(bus.Dval), 32'd11);
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
        curDivisor       = W'(11);
        applyStimulus("200div11", W'(200), 9);
        releaseRun("200div11");

        // Run held through reset: accepted on first edge after release
        @(negedge Clk);
        Reset_Load_Clear = 1'b1;
        bus.SW           = W'(13);
        bus.Run          = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rstrun_done", 32'(bus.Done), 32'd0);
        checkOutput("rstrun_dval", 32'(bus.Dval), 32'd13);
        curDivisor = W'(13);
        applyStimulus("100div13", W'(100), 9);
        releaseRun("100div13");

        // Random operand pairs, nonzero divisor
        for (int i = 0; i < 100; i++) begin
            d = W'($urandom_range(255, 1));
            a = W'($urandom_range(255, 0));
            loadDivisor(d);
            applyStimulus("rand", a, 9);
            releaseRun("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
